// File: rtl/tx_pkg.sv
// Shared definitions for the QPSK transmit frame sequencer: FSM state encoding
// and the alternating preamble dibits.
package tx_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRE   = 2'd1,
        PAY   = 2'd2,
        GUARD = 2'd3
    } state_t;

    localparam logic [1:0] PRE_EVEN = 2'b00;
    localparam logic [1:0] PRE_ODD  = 2'b11;

    function automatic logic [1:0] preDibit(input logic isOdd);
        return isOdd ? PRE_ODD : PRE_EVEN;
    endfunction

endpackage

// File: rtl/tx_sym_timer.sv
// Symbol pacing counter: counts 0..SYM_DIV-1 while running and flags the last
// cycle of each symbol period.
module tx_sym_timer #(
    parameter int SYM_DIV = 4
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_clear,
    input  logic i_run,
    output logic o_tick
);

    localparam int CW = (SYM_DIV > 2) ? $clog2(SYM_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(SYM_DIV - 1);

    logic [CW-1:0] r_count;

    always_ff @(posedge i_clk) begin
        if (i_reset || i_clear) begin
            r_count <= '0;
        end else if (i_run) begin
            r_count <= (r_count == LAST) ? '0 : r_count + 1'b1;
        end
    end

    assign o_tick = i_run && (r_count == LAST);

endmodule

// File: rtl/tx_frame_sequencer.sv
// Frame controller for the QPSK transmitter: preamble -> payload -> guard,
// paced by a symbol timer, with per-frame optional single-symbol error injection.
module tx_frame_sequencer
    import tx_pkg::*;
#(
    parameter int SYM_DIV      = 4,
    parameter int PREAMBLE_LEN = 8,
    parameter int PAYLOAD_LEN  = 32,
    parameter int GUARD_LEN    = 4
) (
    input  logic       sys_clk,
    input  logic       reset,
    input  logic       start,
    input  logic       err_en,
    input  logic [7:0] err_pos,
    input  logic       pay_valid,
    input  logic [1:0] pay_data,
    output logic       pay_ready,
    output logic       sym_stb,
    output logic [1:0] sym_out,
    output logic       IsTransmit,
    output logic       has_error,
    output logic       busy,
    output logic       frame_done,
    output logic       underrun,
    output logic [7:0] frame_cnt
);

    localparam int MAX_PG  = (PREAMBLE_LEN > GUARD_LEN) ? PREAMBLE_LEN : GUARD_LEN;
    localparam int MAX_LEN = (MAX_PG > PAYLOAD_LEN) ? MAX_PG : PAYLOAD_LEN;
    // At least 8 bits so the latched error position can be compared directly.
    localparam int SIDX_W  = (MAX_LEN > 256) ? $clog2(MAX_LEN) : 8;

    state_t            r_state;
    state_t            w_nextState;
    logic [SIDX_W-1:0] r_sidx;
    logic              w_tick;
    logic              r_errEn;
    logic [7:0]        r_errPos;
    logic              r_symStb;
    logic [1:0]        r_symOut;
    logic              r_hasError;
    logic              r_isTx;
    logic              r_underrun;
    logic [7:0]        r_frameCnt;

    logic              w_emit;
    logic [1:0]        w_emitData;
    logic              w_emitErr;
    logic              w_payReady;
    logic              w_frameDone;

    tx_sym_timer #(
        .SYM_DIV (SYM_DIV)
    ) u_timer (
        .i_clk   (sys_clk),
        .i_reset (reset),
        .i_clear (r_state == IDLE),
        .i_run   (r_state != IDLE),
        .o_tick  (w_tick)
    );

    always_ff @(posedge sys_clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        w_emit      = 1'b0;
        w_emitData  = 2'b00;
        w_emitErr   = 1'b0;
        w_payReady  = 1'b0;
        w_frameDone = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_nextState = PRE;
                end
            end
            PRE: begin
                if (w_tick) begin
                    w_emit     = 1'b1;
                    w_emitData = preDibit(r_sidx[0]);
                    if (r_sidx == SIDX_W'(PREAMBLE_LEN - 1)) begin
                        w_nextState = PAY;
                    end
                end
            end
            PAY: begin
                if (w_tick) begin
                    // A missing dibit still occupies its slot so frame timing never stretches.
                    w_payReady = 1'b1;
                    w_emit     = 1'b1;
                    w_emitData = pay_valid ? pay_data : 2'b00;
                    w_emitErr  = r_errEn && (r_sidx == SIDX_W'(r_errPos));
                    if (r_sidx == SIDX_W'(PAYLOAD_LEN - 1)) begin
                        w_nextState = GUARD;
                    end
                end
            end
            GUARD: begin
                if (w_tick && (r_sidx == SIDX_W'(GUARD_LEN - 1))) begin
                    w_nextState = IDLE;
                    w_frameDone = 1'b1;
                end
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (reset) begin
            r_sidx   <= '0;
            r_errEn  <= 1'b0;
            r_errPos <= 8'd0;
        end else begin
            if (w_nextState != r_state) begin
                r_sidx <= '0;
            end else if (w_tick) begin
                r_sidx <= r_sidx + 1'b1;
            end
            if ((r_state == IDLE) && start) begin
                r_errEn  <= err_en;
                r_errPos <= err_pos;
            end
        end
    end

    // IsTransmit drops one cycle after the last payload strobe, i.e. on the first GUARD edge.
    always_ff @(posedge sys_clk) begin
        if (reset) begin
            r_symStb   <= 1'b0;
            r_symOut   <= 2'b00;
            r_hasError <= 1'b0;
            r_isTx     <= 1'b0;
            r_underrun <= 1'b0;
            r_frameCnt <= 8'd0;
        end else begin
            r_symStb   <= w_emit;
            r_symOut   <= w_emitData;
            r_hasError <= w_emitErr;
            if ((r_state == PRE) && w_tick) begin
                r_isTx <= 1'b1;
            end else if ((r_state == GUARD) || (r_state == IDLE)) begin
                r_isTx <= 1'b0;
            end
            r_underrun <= r_underrun | (w_payReady & ~pay_valid);
            r_frameCnt <= r_frameCnt + {7'd0, w_frameDone};
        end
    end

    assign pay_ready  = w_payReady;
    assign sym_stb    = r_symStb;
    assign sym_out    = r_symOut;
    assign has_error  = r_hasError;
    assign IsTransmit = r_isTx;
    assign busy       = (r_state != IDLE);
    assign frame_done = w_frameDone;
    assign underrun   = r_underrun;
    assign frame_cnt  = r_frameCnt;

endmodule

// File: tb/tb_tx_frame_sequencer.sv
// Scoreboard bench for tx_frame_sequencer: a frame-level timing model predicts
// every strobe, control output and counter from the start/reset history.
module tb_tx_frame_sequencer;

   localparam int D     = 4;
   localparam int PRE   = 8;
   localparam int PAY   = 32;
   localparam int GRD   = 4;
   localparam int NSYM  = PRE + PAY;
   localparam int FRAME = (PRE + PAY + GRD) * D;
   localparam int BIG   = 32'h3fff_ffff;

   logic       sys_clk = 1'b0;
   logic       reset = 1'b1;
   logic       start = 1'b0;
   logic       err_en = 1'b0;
   logic [7:0] err_pos = 8'd0;
   logic       pay_valid = 1'b0;
   logic [1:0] pay_data = 2'b00;
   logic       pay_ready;
   logic       sym_stb;
   logic [1:0] sym_out;
   logic       IsTransmit;
   logic       has_error;
   logic       busy;
   logic       frame_done;
   logic       underrun;
   logic [7:0] frame_cnt;

   tx_frame_sequencer #(
      .SYM_DIV      (D),
      .PREAMBLE_LEN (PRE),
      .PAYLOAD_LEN  (PAY),
      .GUARD_LEN    (GRD)
   ) dut (
      .sys_clk    (sys_clk),
      .reset      (reset),
      .start      (start),
      .err_en     (err_en),
      .err_pos    (err_pos),
      .pay_valid  (pay_valid),
      .pay_data   (pay_data),
      .pay_ready  (pay_ready),
      .sym_stb    (sym_stb),
      .sym_out    (sym_out),
      .IsTransmit (IsTransmit),
      .has_error  (has_error),
      .busy       (busy),
      .frame_done (frame_done),
      .underrun   (underrun),
      .frame_cnt  (frame_cnt)
   );

   always #5 sys_clk = ~sys_clk;

   typedef struct {
      int         cyc;
      logic [1:0] d;
      logic       e;
   } sym_t;

   sym_t       sbQ[$];
   int         doneQ[$];
   int         cyc = 0;
   int         vectors = 0;
   int         miscompares = 0;
   bit         monOn = 1'b0;
   bit         mAct = 1'b0;
   int         mS = 0;
   int         mCnt = 0;
   int         mAccepted = 0;
   int         underrunAt = BIG;
   bit         planV[PAY];
   logic [1:0] planD[PAY];
   bit         fV[PAY];
   logic [1:0] fD[PAY];

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      vectors++;
      if (actual !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s: got %0d, want %0d (cycle %0d)", name, actual, expected, cyc);
      end
   endtask

   // Payload symbol index whose tick falls in the cycle after edge c, or -1.
   function automatic int paySlotAt(input int c);
      int r;
      int n;
      r = c - mS + 1;
      if (!mAct || r <= 0 || (r % D) != 0) return -1;
      n = r / D - 1;
      if (n >= PRE && n < NSYM) return n - PRE;
      return -1;
   endfunction

   // A frame occupies NSYM strobes one symbol apart, then GRD silent symbols.
   task automatic acceptFrame();
      sym_t s;
      mS = cyc;
      mAct = 1'b1;
      mAccepted++;
      for (int j = 0; j < PAY; j++) begin
         fV[j] = planV[j];
         fD[j] = planD[j];
      end
      for (int n = 0; n < NSYM; n++) begin
         s.cyc = mS + (n + 1) * D;
         if (n < PRE) begin
            s.d = (n % 2 == 1) ? 2'b11 : 2'b00;
            s.e = 1'b0;
         end else begin
            s.d = fV[n - PRE] ? fD[n - PRE] : 2'b00;
            s.e = err_en && ((n - PRE) == int'(err_pos));
            if (!fV[n - PRE] && (s.cyc < underrunAt)) underrunAt = s.cyc;
         end
         sbQ.push_back(s);
      end
      doneQ.push_back(mS + FRAME - 1);
   endtask

   // Reference model advances on each rising edge using the bench's own inputs.
   initial forever begin
      bit wasIdle;
      @(posedge sys_clk);
      cyc = cyc + 1;
      wasIdle = !mAct;
      if (reset) begin
         mAct = 1'b0;
         mCnt = 0;
         underrunAt = BIG;
         sbQ.delete();
         doneQ.delete();
      end else begin
         if (mAct && (cyc == mS + FRAME)) begin
            mAct = 1'b0;
            mCnt = (mCnt + 1) % 256;
         end
         if (start && wasIdle) acceptFrame();
      end
   end

   // Upstream source: planned dibit only on predicted payload ticks, random junk elsewhere.
   initial forever begin
      int j;
      @(negedge sys_clk);
      j = paySlotAt(cyc);
      if (j >= 0) begin
         pay_valid = fV[j];
         pay_data  = fD[j];
      end else begin
         pay_valid = 1'($urandom_range(0, 1));
         pay_data  = 2'($urandom_range(0, 3));
      end
   end

   // Monitor: pops expected strobes/frame ends and checks level outputs every cycle.
   initial forever begin
      sym_t sbExp;
      @(negedge sys_clk);
      if (monOn) begin
         if (sym_stb === 1'b1) begin
            if (sbQ.size() == 0) begin
               checkOutput("sym_stb unexpected", 32'(sym_stb), 32'd0);
            end else begin
               sbExp = sbQ.pop_front();
               checkOutput("strobe cycle", cyc, sbExp.cyc);
               checkOutput("sym_out", 32'(sym_out), 32'(sbExp.d));
               checkOutput("has_error", 32'(has_error), 32'(sbExp.e));
            end
         end else begin
            checkOutput("sym_out idle", 32'(sym_out), 32'd0);
            checkOutput("has_error idle", 32'(has_error), 32'd0);
            if (sbQ.size() > 0 && sbQ[0].cyc <= cyc) begin
               sbExp = sbQ.pop_front();
               checkOutput("sym_stb missing", 32'(sym_stb), 32'd1);
            end
         end
         if (frame_done === 1'b1) begin
            if (doneQ.size() == 0) checkOutput("frame_done unexpected", 32'(frame_done), 32'd0);
            else checkOutput("frame_done cycle", cyc, doneQ.pop_front());
         end else if (doneQ.size() > 0 && doneQ[0] <= cyc) begin
            void'(doneQ.pop_front());
            checkOutput("frame_done missing", 32'(frame_done), 32'd1);
         end
         checkOutput("IsTransmit", 32'(IsTransmit), 32'(mAct && cyc >= mS + D && cyc <= mS + NSYM * D));
         checkOutput("busy", 32'(busy), 32'(mAct));
         checkOutput("pay_ready", 32'(pay_ready), 32'(paySlotAt(cyc) >= 0));
         checkOutput("underrun", 32'(underrun), 32'(cyc >= underrunAt));
         checkOutput("frame_cnt", 32'(frame_cnt), mCnt);
      end
   end

   task automatic setPlan(input int mode);
      for (int j = 0; j < PAY; j++) begin
         case (mode)
            0: begin planV[j] = 1'b1; planD[j] = 2'(j % 4); end
            1: begin planV[j] = (j != 10) && (j != 11); planD[j] = 2'(j % 4); end
            default: begin planV[j] = ($urandom_range(0, 7) != 0); planD[j] = 2'($urandom_range(0, 3)); end
         endcase
      end
   endtask

   task automatic waitIdle(input int budget);
      int k = 0;
      while ((mAct || sbQ.size() > 0 || doneQ.size() > 0) && k < budget) begin
         @(negedge sys_clk);
         k++;
      end
      if (k >= budget) begin
         vectors++;
         miscompares++;
         $display("[TB] FAIL idle wait: still busy after %0d cycles, want idle", k);
      end
      @(negedge sys_clk);
   endtask

   task automatic applyStimulus(input bit en, input int pos);
      err_en = en;
      err_pos = 8'(pos);
      start = 1'b1;
      @(negedge sys_clk);
      start = 1'b0;
      err_en = 1'($urandom_range(0, 1));
      err_pos = 8'($urandom_range(0, 255));
   endtask

   task automatic pulseReset();
      reset = 1'b1;
      @(negedge sys_clk);
      reset = 1'b0;
   endtask

   initial begin
      int base;
      int k;
      for (int j = 0; j < PAY; j++) begin
         planV[j] = 1'b1;
         planD[j] = 2'b00;
         fV[j] = 1'b0;
         fD[j] = 2'b00;
      end

      // Reset held three cycles, then every output must read zero.
      reset = 1'b1;
      @(negedge sys_clk);
      monOn = 1'b1;
      repeat (2) @(negedge sys_clk);
      reset = 1'b0;
      @(negedge sys_clk);
      checkOutput("reset sym_stb", 32'(sym_stb), 32'd0);
      checkOutput("reset IsTransmit", 32'(IsTransmit), 32'd0);
      checkOutput("reset busy", 32'(busy), 32'd0);
      checkOutput("reset underrun", 32'(underrun), 32'd0);
      checkOutput("reset frame_cnt", 32'(frame_cnt), 32'd0);

      // Plain frame with a cycling payload.
      setPlan(0);
      applyStimulus(1'b0, 0);
      waitIdle(FRAME + 20);
      checkOutput("frame_cnt after one frame", 32'(frame_cnt), 32'd1);
      checkOutput("no underrun", 32'(underrun), 32'd0);

      // Error injection at an in-range and an out-of-range position.
      setPlan(2);
      applyStimulus(1'b1, 5);
      waitIdle(FRAME + 20);
      setPlan(2);
      applyStimulus(1'b1, 40);
      waitIdle(FRAME + 20);

      // Payload gap on symbols 10-11, then a clean frame to show underrun is sticky.
      pulseReset();
      setPlan(1);
      applyStimulus(1'b0, 0);
      waitIdle(FRAME + 20);
      checkOutput("underrun set", 32'(underrun), 32'd1);
      setPlan(0);
      applyStimulus(1'b0, 0);
      waitIdle(FRAME + 20);
      checkOutput("underrun sticky", 32'(underrun), 32'd1);

      // Reset in the middle of payload symbol 20, then a full frame.
      setPlan(2);
      applyStimulus(1'b1, 25);
      k = 0;
      while (cyc < mS + (PRE + 20) * D + 1 && k < FRAME) begin
         @(negedge sys_clk);
         k++;
      end
      pulseReset();
      checkOutput("busy after reset", 32'(busy), 32'd0);
      checkOutput("frame_done after reset", 32'(frame_done), 32'd0);
      checkOutput("frame_cnt after reset", 32'(frame_cnt), 32'd0);
      setPlan(2);
      applyStimulus(1'b1, 31);
      waitIdle(FRAME + 20);
      checkOutput("frame_cnt after restart", 32'(frame_cnt), 32'd1);

      // start held high: 300 back-to-back frames with random errors and payload.
      pulseReset();
      setPlan(2);
      base = mAccepted;
      start = 1'b1;
      k = 0;
      while ((mAccepted - base) < 300 && k < 300 * (FRAME + 2)) begin
         err_en = 1'($urandom_range(0, 1));
         err_pos = 8'($urandom_range(0, 47));
         planV[$urandom_range(0, PAY - 1)] = ($urandom_range(0, 15) != 0);
         planD[$urandom_range(0, PAY - 1)] = 2'($urandom_range(0, 3));
         @(negedge sys_clk);
         k++;
      end
      start = 1'b0;
      checkOutput("frames accepted", mAccepted - base, 300);
      waitIdle(FRAME + 20);
      checkOutput("frame_cnt wrap", 32'(frame_cnt), 32'd44);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation time limit reached, want completion");
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
